// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for memory-mapped peripherals on the RISC-V data bus:
// register offsets, STATUS bit layout and the UART transmitter state type.
package riscv_mmio_pkg;

  // Byte offsets inside the 16-byte register window
  localparam logic [3:0] TXDATA_OFF = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] DIV_OFF    = 4'h8;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // A programmed divisor of zero is treated as one clock per bit
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic                       push_ok,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign push_ok = do_push;
  assign dout    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  // Storage is plain RAM: no reset, written only on accepted pushes
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting on the core's data bus beside
// the data memory; bytes queue in a small FIFO and leave LSB first on tx.
module mmio_uart_tx
  import riscv_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h10010100,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] DIV_RESET    = 16'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_i,
  input  logic        MemWrite,
  output logic [31:0] data_o,
  output logic        sel,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    reg_off;
  logic          wr_en;
  logic          push_req;
  logic          push_ok;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic          unused_bus_bits;

  logic          overflow_reg;
  logic [15:0]   div_reg;

  uart_state_t   state_reg,   state_next;
  logic [7:0]    shift_reg,   shift_next;
  logic [15:0]   bit_len_reg, bit_len_next;
  logic [15:0]   bit_cnt_reg, bit_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic          tx_reg,      tx_next;
  logic          bit_done;

  // Address decode: the window is 16-byte aligned, byte lanes are ignored
  assign sel             = (address[31:4] == BASE_ADDRESS[31:4]);
  assign reg_off         = {address[3:2], 2'b00};
  assign wr_en           = MemWrite && sel;
  assign push_req        = wr_en && (reg_off == TXDATA_OFF);
  assign unused_bus_bits = ^{address[1:0], data_i[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_req),
    .din     (data_i[7:0]),
    .pop     (fifo_pop),
    .push_ok (push_ok),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
      div_reg      <= DIV_RESET;
    end else begin
      if (wr_en && (reg_off == STATUS_OFF)) begin
        overflow_reg <= 1'b0;
      end else if (push_req && !push_ok) begin
        overflow_reg <= 1'b1;
      end
      if (wr_en && (reg_off == DIV_OFF)) begin
        div_reg <= data_i[15:0];
      end
    end
  end

  always_comb begin
    status                                 = '0;
    status[STAT_BUSY]                      = (state_reg != IDLE);
    status[STAT_FULL]                      = fifo_full;
    status[STAT_EMPTY]                     = fifo_empty;
    status[STAT_OVF]                       = overflow_reg;
    status[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(fifo_count);
  end

  always_comb begin
    data_o = '0;
    if (sel) begin
      case (reg_off)
        STATUS_OFF: data_o = status;
        DIV_OFF:    data_o = {16'd0, div_reg};
        default:    data_o = '0;
      endcase
    end
  end

  assign bit_done = (bit_cnt_reg == (bit_len_reg - 16'd1));

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_len_next = bit_len_reg;
    bit_cnt_next = bit_cnt_reg;
    bit_idx_next = bit_idx_reg;
    fifo_pop     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_next   = fifo_dout;
          bit_len_next = eff_div(div_reg);
          bit_cnt_next = 16'd0;
          state_next   = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_cnt_next = 16'd0;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end else begin
          bit_cnt_next = bit_cnt_reg + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_cnt_next = 16'd0;
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          bit_cnt_next = 16'd0;
          state_next   = IDLE;
        end else begin
          bit_cnt_next = bit_cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is derived from the upcoming state so tx can be registered
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      shift_reg   <= 8'd0;
      bit_len_reg <= 16'd0;
      bit_cnt_reg <= 16'd0;
      bit_idx_reg <= 3'd0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_len_reg <= bit_len_next;
      bit_cnt_reg <= bit_cnt_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
    end
  end

  assign tx = tx_reg;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. It acts as a responder on the RISC-V core's data-memory bus, in the same position as the data Memory instance.
- The core writes bytes into a 4-entry FIFO. An 8N1 serializer shifts them out on `tx`, LSB first.
- Status and baud-divisor registers are readable on the same bus. The top level muxes this block's `data_o` onto the core's `data_i` when `sel` is high.

Parameters:
- BASE_ADDRESS, 32'h10010100, byte address of register window (16-byte aligned).
- FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2).
- DIV_RESET, 16'd4, reset value of the DIV register (clock cycles per bit).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  32  byte address from core (dataAddress).
- data_i  in  32  write data from core.
- MemWrite  in  1  write strobe from core.
- data_o  out  32  read data to core; combinational.
- sel  out  1  high when address lies in [BASE_ADDRESS, BASE_ADDRESS+15]; combinational.
- tx  out  1  serial line, idle high.

Behaviour:
- Register map (offsets from BASE_ADDRESS; address[1:0] ignored):
  - 0x0 TXDATA: write-only; data_i[7:0] is pushed. Reads return 0.
  - 0x4 STATUS: read-only. bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[6:4] FIFO count, other bits 0. Any write clears overflow.
  - 0x8 DIV: R/W, bits[15:0]; upper bits read 0. A value of 0 behaves as 1.
  - 0xC: reads 0; writes ignored.
- Reads: data_o is combinational from address and current state, with zero added latency. When sel=0, data_o=0.
- Writes take effect on the clock edge where MemWrite=1 and sel=1.
- Reset (asynchronous, while reset=0):
  - tx=1, FIFO empty, overflow=0, DIV=DIV_RESET, FSM=IDLE, counters 0.
  - Reset asserted mid-frame forces tx=1 immediately; the partial frame is abandoned.
- Push rule:
  - A TXDATA write is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Simultaneous push and pop: count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO not empty, pop the head into the shift register, latch DIV into bit_len, and go to START. tx goes low on the cycle after the pop.
  - START: tx=0 for bit_len cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0] for bit_len cycles, then shift right and increment bit_idx. After bit_idx 7 completes, go to STOP.
  - STOP: tx=1 for bit_len cycles, then go to IDLE.
- Back-to-back frames: after STOP, IDLE sees a non-empty FIFO and pops the next byte. This inserts exactly 1 idle cycle (tx=1) between frames.
- Frame length is 10*bit_len cycles plus that 1 IDLE cycle.
- Writing DIV mid-frame does not affect the current frame; the new value is used from the next pop.
- The tx output is registered, so there are no glitches.
- Bit counter width is 16. Count width is clog2(FIFO_DEPTH)+1.
- FIFO pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package riscv_mmio_pkg:
  - register offsets (TXDATA_OFF, STATUS_OFF, DIV_OFF);
  - STATUS bit positions;
  - typedef enum logic [1:0] uart_state_t {IDLE, START, DATA, STOP}.
- Sub-module sync_fifo (WIDTH=8, DEPTH): push/pop/full/empty/count, same clock and asynchronous active-low reset. It is reusable for a future RX block.

Test Plan:
- Reset: hold reset=0, then release. Required: tx=1, STATUS read = 0x4 (empty), DIV read = 0x4, sel=0 at address 0x10010000.
- Single byte: write 0x55 to TXDATA with DIV=4. Required:
  - tx low 1 cycle after the pop edge;
  - 4 cycles of 0, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then 4 cycles of 1;
  - busy=1 throughout; STATUS=0x4 afterwards.
- Overflow: set DIV=100, write 6 bytes 0x01..0x06 in consecutive cycles. Required:
  - the first pops immediately, the next 4 fill the FIFO, the 6th is dropped;
  - STATUS = 0x4B (count 4, overflow, full, busy).
  - Then write STATUS. Required: bit3 clears.
- Back-to-back: write 0xA0 and 0x0F with DIV=2. Required: exactly 1 cycle of tx=1 between the stop bit of frame 1 and the start bit of frame 2; total span 41 cycles.
- DIV change mid-frame: DIV=3, write 0xFF, then write DIV=8 during DATA. Required: current frame keeps 3-cycle bits; the next byte uses 8-cycle bits.
- Asynchronous reset mid-frame: assert reset between clock edges during DATA. Required:
  - tx=1 and busy=0 immediately, without waiting for a clock edge;
  - after release, FIFO empty and no residual frame.
